// File: rtl/bin_clock_led_shifter_if.sv
// Time-value / serial-display bundle for bin_clock_led_shifter.
// Signal names keep the shifter's point of view: _i flows into the shifter and _o flows out of it.
// master = clock core / pin side, slave = the shifter itself.
interface bin_clock_led_shifter_if;
    logic [3:0] hour_i;
    logic [5:0] minute_i;
    logic [5:0] seconds_i;
    logic       update_i;
    logic       busy_o;
    logic       sclk_o;
    logic       sdata_o;
    logic       latch_o;
    logic       done_o;

    modport master (
        output hour_i, minute_i, seconds_i, update_i,
        input  busy_o, sclk_o, sdata_o, latch_o, done_o
    );

    modport slave (
        input  hour_i, minute_i, seconds_i, update_i,
        output busy_o, sclk_o, sdata_o, latch_o, done_o
    );
endinterface

// File: rtl/bin_clock_led_shifter.sv
// Serial display transmitter for the binary clock.
// Shifts {hour[3:0], minute[5:0], seconds[5:0]} MSB-first into a 74HC595-style chain.
// It then pulses the latch so that every LED updates at the same time.
// A request made while a frame is in flight is merged into a single pending flag.
// That pending frame starts directly from DONE, with no idle gap.
// Optional macro BIN_CLOCK_PARITY_EN appends one even-parity bit after seconds[0].
// With the macro, a frame is 17 bits long.
// CLK_DIV: system clocks per sclk half-period, legal range 1..255.
module bin_clock_led_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    bin_clock_led_shifter_if.slave bus
);

    localparam int unsigned FRAME_BITS = 16;
`ifdef BIN_CLOCK_PARITY_EN
    localparam int unsigned NUM_BITS = FRAME_BITS + 1;
`else
    localparam int unsigned NUM_BITS = FRAME_BITS;
`endif
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [4:0]            bit_q, bit_d;
    logic [NUM_BITS-1:0]   shreg_q, shreg_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  latch_q, latch_d;
    logic                  done_q, done_d;

    logic [FRAME_BITS-1:0] frame_data;
    logic [NUM_BITS-1:0]   frame_word;
    logic                  phase_end;

    assign frame_data = {bus.hour_i, bus.minute_i, bus.seconds_i};
`ifdef BIN_CLOCK_PARITY_EN
    assign frame_word = {frame_data, ^frame_data};
`else
    assign frame_word = frame_data;
`endif

    assign phase_end = (div_q == DIV_LAST);

    // Next-state logic: phase timing, bit sequencing and merging of pending requests.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        pending_d = pending_q;

        // Requests that arrive mid-frame collapse into one flag; DONE consumes it below.
        if (bus.update_i && (state_q inside {StShiftLo, StShiftHi, StLatch})) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.update_i) begin
                    state_d = StShiftLo;
                    shreg_d = frame_word;
                    bit_d   = BIT_LAST;
                    div_d   = 8'd0;
                end
            end
            StShiftLo: begin
                if (phase_end) begin
                    state_d = StShiftHi;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StShiftHi: begin
                if (phase_end) begin
                    div_d = 8'd0;
                    if (bit_q == 5'd0) begin
                        state_d = StLatch;
                    end else begin
                        state_d = StShiftLo;
                        shreg_d = {shreg_q[NUM_BITS-2:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StLatch: begin
                if (phase_end) begin
                    state_d = StDone;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StDone: begin
                pending_d = 1'b0;
                // A request on this edge counts as pending: restart with no idle gap.
                if (pending_q || bus.update_i) begin
                    state_d = StShiftLo;
                    shreg_d = frame_word;
                    bit_d   = BIT_LAST;
                    div_d   = 8'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state, so that every pin comes straight from a flop.
    always_comb begin
        busy_d  = (state_d != StIdle);
        sclk_d  = (state_d == StShiftHi);
        sdata_d = 1'b0;
        if ((state_d == StShiftLo) || (state_d == StShiftHi)) begin
            sdata_d = shreg_d[NUM_BITS-1];
        end
        latch_d = (state_d == StLatch);
        done_d  = (state_d == StDone);
    end

    // State and output registers; reset drops every pin immediately and emits no latch pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            div_q     <= 8'd0;
            bit_q     <= 5'd0;
            shreg_q   <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.sclk_o  = sclk_q;
    assign bus.sdata_o = sdata_q;
    assign bus.latch_o = latch_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_bin_clock_led_shifter.sv
// Bench for bin_clock_led_shifter.
// Two instances run side by side: one with CLK_DIV=4 and one with CLK_DIV=1.
// The model is driven only by each frame's start time and data word.
// It derives every output from the cycle offset within the frame.
module tb_bin_clock_led_shifter;

`ifdef BIN_CLOCK_PARITY_EN
    localparam int NB = 17;
    localparam longint W1 = 64'h16F5B;  // 0xB7AD + parity 1
    localparam longint W2 = 64'h19DF6;  // 0xCEFB + parity 0
    localparam longint W3 = 64'h1350E;  // 0x9A87 + parity 0
    localparam longint W4 = 64'h00003;  // 0x0001 + parity 1
    localparam int L4 = 141;
    localparam int L1 = 36;
`else
    localparam int NB = 16;
    localparam longint W1 = 64'hB7AD;
    localparam longint W2 = 64'hCEFB;
    localparam longint W3 = 64'h9A87;
    localparam longint W4 = 64'h0001;
    localparam int L4 = 133;
    localparam int L1 = 34;
`endif
    localparam int D0 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bin_clock_led_shifter_if if4 ();
    bin_clock_led_shifter_if if1 ();

    bin_clock_led_shifter #(.CLK_DIV(D0)) dut4 (.clk_i(clk), .rstn_i(rstn), .bus(if4));
    bin_clock_led_shifter #(.CLK_DIV(D1)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(if1));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    function automatic int flen(input int d);
        return 2 * d * NB + d + 1;
    endfunction

    function automatic logic [NB-1:0] mk_word(input logic [3:0] h, input logic [5:0] m,
                                              input logic [5:0] s);
        logic [15:0] dd;
        dd = {h, m, s};
`ifdef BIN_CLOCK_PARITY_EN
        return {dd, ^dd};
`else
        return dd;
`endif
    endfunction

    // Outputs {busy, sclk, sdata, latch, done} at offset kf into a frame carrying word w.
    function automatic logic [4:0] expect_outs(input int d, input int kf, input logic [NB-1:0] w);
        int sh;
        logic [4:0] r;
        sh = 2 * d * NB;
        r = 5'b0;
        if (kf < flen(d)) r[4] = 1'b1;
        if (kf < sh) begin
            r[3] = ((kf % (2 * d)) >= d);
            r[2] = w[NB - 1 - kf / (2 * d)];
        end
        if (kf >= sh && kf < sh + d) r[1] = 1'b1;
        if (kf == flen(d) - 1) r[0] = 1'b1;
        return r;
    endfunction

    // One clock edge: kf is the offset of the cycle before the edge (>= len means idle).
    function automatic void step(input int d, input logic upd, input logic [NB-1:0] w_in,
                                 input int kf_in, input logic p_in, input logic [NB-1:0] w_cur,
                                 output int kf_o, output logic p_o, output logic [NB-1:0] w_o);
        int len;
        len = flen(d);
        kf_o = kf_in;
        p_o = p_in;
        w_o = w_cur;
        if (kf_in >= len) begin
            if (upd) begin
                kf_o = 0;
                w_o = w_in;
                p_o = 1'b0;
            end
        end else if (kf_in == len - 1) begin
            if (p_in || upd) begin
                kf_o = 0;
                w_o = w_in;
            end else begin
                kf_o = len;
            end
            p_o = 1'b0;
        end else begin
            kf_o = kf_in + 1;
            if (upd) p_o = 1'b1;
        end
    endfunction

    int kf[2] = '{1000, 1000};
    logic pend[2] = '{1'b0, 1'b0};
    logic [NB-1:0] mw[2];
    logic [4:0] exp_o[2] = '{5'b0, 5'b0};

    always @(posedge clk or negedge rstn) begin
        int k_n;
        logic p_n;
        logic [NB-1:0] w_n;
        if (!rstn) begin
            kf[0] <= flen(D0);
            kf[1] <= flen(D1);
            pend[0] <= 1'b0;
            pend[1] <= 1'b0;
            exp_o[0] <= 5'b0;
            exp_o[1] <= 5'b0;
        end else begin
            step(D0, if4.update_i, mk_word(if4.hour_i, if4.minute_i, if4.seconds_i),
                 kf[0], pend[0], mw[0], k_n, p_n, w_n);
            kf[0] <= k_n;
            pend[0] <= p_n;
            mw[0] <= w_n;
            exp_o[0] <= expect_outs(D0, k_n, w_n);
            step(D1, if1.update_i, mk_word(if1.hour_i, if1.minute_i, if1.seconds_i),
                 kf[1], pend[1], mw[1], k_n, p_n, w_n);
            kf[1] <= k_n;
            pend[1] <= p_n;
            mw[1] <= w_n;
            exp_o[1] <= expect_outs(D1, k_n, w_n);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0] act[2];
    assign act[0] = {if4.busy_o, if4.sclk_o, if4.sdata_o, if4.latch_o, if4.done_o};
    assign act[1] = {if1.busy_o, if1.sclk_o, if1.sdata_o, if1.latch_o, if1.done_o};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act[i] !== exp_o[i]) begin
                n_err++;
                $display("FAIL model_cycle dut%0d t=%0t busy/sclk/sdata/latch/done got %b want %b",
                         i, $time, act[i], exp_o[i]);
            end
        end
    end

    // ---------------- measurement for literal checks ----------------
    int edges[2] = '{0, 0};
    int latch_cyc[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int busy_run[2] = '{0, 0};
    int last_run[2] = '{0, 0};
    logic psclk[2] = '{1'b0, 1'b0};
    logic [63:0] rx[2] = '{64'd0, 64'd0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (act[i][3] && !psclk[i]) begin
                edges[i]++;
                rx[i] = {rx[i][62:0], act[i][2]};
            end
            psclk[i] = act[i][3];
            if (act[i][1]) latch_cyc[i]++;
            if (act[i][0]) done_cnt[i]++;
            if (act[i][4]) begin
                busy_run[i]++;
            end else begin
                if (busy_run[i] != 0) last_run[i] = busy_run[i];
                busy_run[i] = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_done(input int i, input int target, input int maxc);
        int c;
        c = 0;
        while (done_cnt[i] < target && c < maxc) begin
            tick();
            c++;
        end
        chk("wait_done_in_budget", longint'(done_cnt[i] >= target), 1);
    endtask

    task automatic set4(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s);
        if4.hour_i = h;
        if4.minute_i = m;
        if4.seconds_i = s;
    endtask

    task automatic pulse4();
        if4.update_i = 1'b1;
        tick();
        if4.update_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, l0, hold4, hold1;
        set4(4'd0, 6'd0, 6'd0);
        if4.update_i = 1'b0;
        if1.hour_i = 4'd0;
        if1.minute_i = 6'd0;
        if1.seconds_i = 6'd0;
        if1.update_i = 1'b0;
        rstn = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("reset_outs_dut4", act[0], 0);
        chk("reset_outs_dut1", act[1], 0);
        rstn = 1'b1;
        repeat (5) tick();
        chk("idle_after_reset_dut4", act[0], 0);
        chk("idle_after_reset_dut1", act[1], 0);

        // Single frame 11:30:45.
        d0 = done_cnt[0];
        e0 = edges[0];
        l0 = latch_cyc[0];
        set4(4'd11, 6'd30, 6'd45);
        pulse4();
        wait_done(0, d0 + 1, 400);
        tick();
        tick();
        chk("frame1_word", longint'(rx[0][NB-1:0]), W1);
        chk("frame1_edges", edges[0] - e0, NB);
        chk("frame1_busy_len", last_run[0], L4);
        chk("frame1_latch_len", latch_cyc[0] - l0, 4);
        chk("frame1_done_pulses", done_cnt[0] - d0, 1);

        // Pending request merged, new inputs captured at DONE.
        d0 = done_cnt[0];
        e0 = edges[0];
        pulse4();
        repeat (39) tick();
        pulse4();
        repeat (39) tick();
        pulse4();
        repeat (30) tick();
        set4(4'd12, 6'd59, 6'd59);
        wait_done(0, d0 + 2, 700);
        chk("pending_frame2_word", longint'(rx[0][NB-1:0]), W2);
        tick();
        tick();
        chk("pending_no_gap_run", last_run[0], 2 * L4);
        chk("pending_edges", edges[0] - e0, 2 * NB);
        repeat (L4 + 20) tick();
        chk("pending_no_third_frame", done_cnt[0] - d0, 2);
        chk("pending_idle", act[0], 0);

        // Reset after the 5th sclk rising edge.
        e0 = edges[0];
        l0 = latch_cyc[0];
        set4(4'd5, 6'd17, 6'd33);
        pulse4();
        for (int c = 0; c < 300 && (edges[0] - e0) < 5; c++) tick();
        chk("midreset_reached_5_edges", edges[0] - e0, 5);
        rstn = 1'b0;
        #1;
        chk("midreset_async_outs", act[0], 0);
        repeat (2) tick();
        chk("midreset_no_latch", latch_cyc[0] - l0, 0);
        rstn = 1'b1;
        tick();
        d0 = done_cnt[0];
        e0 = edges[0];
        l0 = latch_cyc[0];
        set4(4'd9, 6'd42, 6'd7);
        pulse4();
        wait_done(0, d0 + 1, 400);
        tick();
        tick();
        chk("after_reset_word", longint'(rx[0][NB-1:0]), W3);
        chk("after_reset_edges", edges[0] - e0, NB);
        chk("after_reset_latch_len", latch_cyc[0] - l0, 4);
        chk("after_reset_busy_len", last_run[0], L4);

        // CLK_DIV=1, frame 0x0001.
        d0 = done_cnt[1];
        e0 = edges[1];
        if1.seconds_i = 6'd1;
        if1.update_i = 1'b1;
        tick();
        if1.update_i = 1'b0;
        wait_done(1, d0 + 1, 100);
        tick();
        tick();
        chk("div1_word", longint'(rx[1][NB-1:0]), W4);
        chk("div1_last_bit", longint'(rx[1][0]), 1);
        chk("div1_edges", edges[1] - e0, NB);
        chk("div1_busy_len", last_run[1], L1);

        // Randomized traffic, including long held requests and one reset.
        hold4 = 0;
        hold1 = 0;
        for (int t = 0; t < 3000; t++) begin
            set4(4'($urandom), 6'($urandom), 6'($urandom));
            if1.hour_i = 4'($urandom);
            if1.minute_i = 6'($urandom);
            if1.seconds_i = 6'($urandom);
            if (hold4 > 0) begin
                if4.update_i = 1'b1;
                hold4--;
            end else begin
                if4.update_i = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 199) == 0) hold4 = $urandom_range(5, 300);
            end
            if (hold1 > 0) begin
                if1.update_i = 1'b1;
                hold1--;
            end else begin
                if1.update_i = ($urandom_range(0, 99) < 5);
                if ($urandom_range(0, 199) == 0) hold1 = $urandom_range(5, 100);
            end
            if (t == 1500) rstn = 1'b0;
            if (t == 1502) rstn = 1'b1;
            tick();
        end
        if4.update_i = 1'b0;
        if1.update_i = 1'b0;
        for (int c = 0; c < 1000 && (act[0][4] || act[1][4]); c++) tick();
        tick();
        chk("random_end_idle_dut4", act[0], 0);
        chk("random_end_idle_dut1", act[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
